sipo: RTL and testbench
=======================

SIPO -- requirements
Module: sipo

Interface
REQ-001 Parameter WIDTH, default 4, parallel word width in bits; legal range 2..64.
REQ-002 One clock; reset is asynchronous and active-low.
REQ-003 clk_in  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 data_in  input  1  serial data bit.
REQ-006 valid_in  input  1  data_in carries a valid bit this cycle.
REQ-007 ready_out  output  1  sipo can accept a serial bit this cycle.
REQ-008 data_out  output  WIDTH  assembled parallel word.
REQ-009 valid_out  output  1  data_out holds a complete word.
REQ-010 ready_in  input  1  downstream accepts data_out this cycle.

Function
REQ-011 Serial bit accepted on a rising edge iff valid_in=1 and ready_out=1 on that edge.
REQ-012 Internal bit counter 0..WIDTH-1 counts accepted bits; wraps to 0 on the WIDTH-th accepted bit.
REQ-013 Default order MSB-first: the first accepted bit of a word lands in data_out[WIDTH-1], the last in data_out[0]; serial 1,0,1,1 yields 4'b1011.
REQ-014 On the edge accepting the WIDTH-th bit: data_out loads the full word and valid_out=1 from the next cycle (latency 1 clock after last bit).
REQ-015 Output transfer occurs on an edge with valid_out=1 and ready_in=1; valid_out then clears unless a new word completes on the same edge.
REQ-016 data_out and valid_out remain stable while valid_out=1 and ready_in=0.
REQ-017 Bits 0..WIDTH-2 of the next word are accepted while the previous word is still pending (overlap).
REQ-018 ready_out is combinational: ready_out = NOT(valid_out=1 AND ready_in=0 AND counter=WIDTH-1).
REQ-019 Simultaneous word completion and output transfer on one edge: new word loaded, valid_out stays 1, no bubble, no loss.
REQ-020 valid_in=0 cycles hold the counter and partial word; gaps between bits are legal.
REQ-021 data_in ignored when valid_in=0 or ready_out=0.
REQ-022 data_out holds its last word after the transfer; it does not clear.

Reset
REQ-023 rst_n=0 immediately forces counter=0, partial word=0, data_out=0, valid_out=0, independent of clk_in.
REQ-024 ready_out=0 while rst_n=0; equals REQ-018 value (1) from the first cycle after release.
REQ-025 Reset mid-word discards accepted bits; the next accepted bit starts a new word.
REQ-026 rst_n released synchronously by the system; no internal synchronizer.

Configuration
REQ-027 Macro SIPO_LSB_FIRST_EN: when defined, the first accepted bit lands in data_out[0] and the last in data_out[WIDTH-1] (serial 1,0,1,1 yields 4'b1101).
REQ-028 Without SIPO_LSB_FIRST_EN, MSB-first per REQ-013; all other behaviour identical in both builds.

Verification
REQ-029 WIDTH=4, ready_in=1, send 1,0,1,1 on consecutive cycles -> valid_out=1 for one cycle, data_out=4'b1011, one cycle after the 4th bit.
REQ-030 Same stimulus with SIPO_LSB_FIRST_EN defined -> data_out=4'b1101.
REQ-031 ready_in=0, send 8 bits 1,0,1,1,0,1,1,0 continuously -> data_out holds 4'b1011; ready_out=0 when 3 bits of word 2 are accepted; raising ready_in -> 4'b1011 transfers, then 4'b0110 presented.
REQ-032 ready_in=1, continuous 12 bits -> three words back to back, no ready_out drop, valid_out pulses every 4 cycles.
REQ-033 Send 2 bits, assert rst_n=0 between edges -> valid_out, data_out 0 at once; after release send 0,0,1,1 -> data_out=4'b0011.
REQ-034 valid_in toggling 1,0,1,0,... with bits 1,0,1,1 -> data_out=4'b1011; idle cycles do not shift.

Source files
------------

// File: rtl/sipo.sv
// -----------------------------------------------------------------------------
// sipo -- serial-in / parallel-out converter with valid/ready handshakes
//
// Collects WIDTH serial bits arriving on a valid/ready input handshake and
// presents each completed word on a valid/ready parallel output. While a
// finished word waits for the consumer, the first WIDTH-1 bits of the next
// word can still be collected. Only the bit that would complete that next word
// is refused. A word can complete on the same edge the pending word is taken,
// so a continuous stream runs without bubbles.
//
// Parameters
//   WIDTH      parallel word width in bits (legal 2..64, default 4)
//
// Compile-time option
//   SIPO_LSB_FIRST_EN  when defined, the first serial bit of a word lands in
//                      data_out[0]. Otherwise the first bit lands in
//                      data_out[WIDTH-1] (MSB-first).
//
// Ports
//   clk_in     in   1      clock, all state changes on the rising edge
//   rst_n      in   1      asynchronous active-low reset (released synchronously)
//   data_in    in   1      serial data bit
//   valid_in   in   1      data_in carries a bit this cycle
//   ready_out  out  1      a serial bit can be accepted this cycle
//   data_out   out  WIDTH  most recently assembled word
//   valid_out  out  1      data_out holds a word not yet taken downstream
//   ready_in   in   1      downstream takes data_out this cycle
// -----------------------------------------------------------------------------
module sipo #(
  parameter int WIDTH = 4
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             data_in,
  input  logic             valid_in,
  output logic             ready_out,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  input  logic             ready_in
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] r_data;
  logic             r_valid;

  logic             w_last;
  logic             w_accept;
  logic             w_complete;
  logic [WIDTH-1:0] w_next_shift;

  // The counter sits on the last bit position of a word. The bit that would
  // finish the next word is refused only when the pending word is not being
  // taken this cycle, because that is the only case where a word would be
  // lost. While reset is asserted nothing is accepted.
  assign w_last     = (r_count == LAST);
  assign ready_out  = rst_n & ~(r_valid & ~ready_in & w_last);
  assign w_accept   = valid_in & ready_out;
  assign w_complete = w_accept & w_last;

  // The shift direction sets which end of the word the first bit ends up in.
  // After WIDTH shifts, the first bit has travelled to the far end of the word.
`ifdef SIPO_LSB_FIRST_EN
  assign w_next_shift = {data_in, r_shift[WIDTH-1:1]};
`else
  assign w_next_shift = {r_shift[WIDTH-2:0], data_in};
`endif

  // Input side: count accepted bits and build the partial word. On the
  // completing bit the partial register is cleared so that the next word
  // always starts from a clean state. Cycles without an accepted bit leave
  // the counter and the partial word unchanged.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_shift <= '0;
    end else if (w_accept) begin
      if (w_last) begin
        r_count <= '0;
        r_shift <= '0;
      end else begin
        r_count <= r_count + 1'b1;
        r_shift <= w_next_shift;
      end
    end
  end

  // Output side: a completed word is loaded and flagged valid from the next
  // cycle. When the consumer takes the pending word on the same edge that a
  // new word completes, the new word replaces it and valid stays high.
  // Otherwise valid drops once the consumer takes the word. data_out keeps
  // the last word after it has been taken.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (w_complete) begin
      r_data  <= w_next_shift;
      r_valid <= 1'b1;
    end else if (ready_in) begin
      r_valid <= 1'b0;
    end
  end

  assign data_out  = r_data;
  assign valid_out = r_valid;

endmodule

// File: tb/tb_sipo.sv
// -----------------------------------------------------------------------------
// tb_sipo -- self-checking bench for sipo (WIDTH = 4)
//
// A reference model watches the same inputs as the DUT. It pushes every word
// it completes onto a scoreboard queue and pops that word when the consumer
// takes it. On every falling edge the DUT outputs are compared against the
// head of the queue. Directed checks against fixed words cover the MSB-first
// and LSB-first orderings (SIPO_LSB_FIRST_EN).
// -----------------------------------------------------------------------------
module tb_sipo;

  localparam int WIDTH = 4;

  // Expected words for the directed sequences, which depend on the bit order.
`ifdef SIPO_LSB_FIRST_EN
  localparam logic [WIDTH-1:0] EXP_1011 = 4'b1101;
  localparam logic [WIDTH-1:0] EXP_0110 = 4'b0110;
  localparam logic [WIDTH-1:0] EXP_0011 = 4'b1100;
`else
  localparam logic [WIDTH-1:0] EXP_1011 = 4'b1011;
  localparam logic [WIDTH-1:0] EXP_0110 = 4'b0110;
  localparam logic [WIDTH-1:0] EXP_0011 = 4'b0011;
`endif

  logic             clk_in = 1'b0;
  logic             rst_n;
  logic             data_in;
  logic             valid_in;
  logic             ready_in;
  logic             ready_out;
  logic [WIDTH-1:0] data_out;
  logic             valid_out;

  int vectors     = 0;
  int miscompares = 0;

  logic [WIDTH-1:0] sbQueue[$];
  logic [WIDTH-1:0] mPartial = '0;
  logic [WIDTH-1:0] mLast    = '0;
  int               mCount   = 0;
  logic             mRdy;

  sipo #(.WIDTH(WIDTH)) dut (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .data_out  (data_out),
    .valid_out (valid_out),
    .ready_in  (ready_in)
  );

  // Free-running clock with a 10-unit period.
  always #5 clk_in = ~clk_in;

  // Single comparison point: every check is counted, and a mismatch is reported.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at t=%0t", tag, observed, expected, $time);
    end
  endtask

  // Drive one cycle of inputs, then return just after the edge that samples them.
  task automatic applyStimulus(input logic v, input logic d, input logic r);
    valid_in = v;
    data_in  = d;
    ready_in = r;
    @(posedge clk_in);
    #2;
  endtask

  // Puts a serial bit at its position in the word for the selected bit order.
  function automatic logic [WIDTH-1:0] placeBit(input logic [WIDTH-1:0] w,
                                                input int idx, input logic b);
    logic [WIDTH-1:0] r;
    r = w;
`ifdef SIPO_LSB_FIRST_EN
    r[idx] = b;
`else
    r[WIDTH-1-idx] = b;
`endif
    return r;
  endfunction

  // The model's view of input readiness: only a full pending word that is
  // not being taken can block the bit that would finish the next word.
  function automatic logic modelReady();
    return rst_n && !((sbQueue.size() > 0) && !ready_in && (mCount == WIDTH - 1));
  endfunction

  // Reference model. It takes the pending word first, then accepts the
  // incoming bit, so a word that completes on a transfer edge follows on
  // directly.
  always @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sbQueue.delete();
      mPartial = '0;
      mLast    = '0;
      mCount   = 0;
    end else begin
      mRdy = modelReady();
      if ((sbQueue.size() > 0) && ready_in)
        mLast = sbQueue.pop_front();
      if (valid_in && mRdy) begin
        mPartial = placeBit(mPartial, mCount, data_in);
        if (mCount == WIDTH - 1) begin
          sbQueue.push_back(mPartial);
          mPartial = '0;
          mCount   = 0;
        end else begin
          mCount++;
        end
      end
    end
  end

  // Compare the DUT against the scoreboard on every falling edge.
  always @(negedge clk_in) begin
    checkOutput("valid_out", valid_out, sbQueue.size() > 0);
    checkOutput("ready_out", ready_out, modelReady());
    checkOutput("data_out", data_out, (sbQueue.size() > 0) ? sbQueue[0] : mLast);
  end

  // Directed scenarios, followed by a randomised stretch.
  initial begin
    rst_n    = 1'b0;
    valid_in = 1'b0;
    data_in  = 1'b0;
    ready_in = 1'b1;
    #1;
    checkOutput("reset valid_out", valid_out, 1'b0);
    checkOutput("reset data_out", data_out, '0);
    checkOutput("reset ready_out", ready_out, 1'b0);
    repeat (2) @(posedge clk_in);
    #2 rst_n = 1'b1;
    #1 checkOutput("ready after release", ready_out, 1'b1);

    $display("[TB] single word, consumer ready");
    applyStimulus(1, 1, 1);
    applyStimulus(1, 0, 1);
    applyStimulus(1, 1, 1);
    applyStimulus(1, 1, 1);
    valid_in = 1'b0;
    #2;
    checkOutput("word1 data", data_out, EXP_1011);
    checkOutput("word1 valid", valid_out, 1'b1);
    applyStimulus(0, 0, 1);
    #2 checkOutput("word1 one-cycle pulse", valid_out, 1'b0);

    $display("[TB] backpressure with overlapping second word");
    applyStimulus(1, 1, 0);
    applyStimulus(1, 0, 0);
    applyStimulus(1, 1, 0);
    applyStimulus(1, 1, 0);
    applyStimulus(1, 0, 0);
    applyStimulus(1, 1, 0);
    applyStimulus(1, 1, 0);
    #2;
    checkOutput("stall ready_out low", ready_out, 1'b0);
    checkOutput("stall data held", data_out, EXP_1011);
    checkOutput("stall valid held", valid_out, 1'b1);
    applyStimulus(1, 0, 0);
    applyStimulus(1, 0, 0);
    applyStimulus(1, 0, 0);
    applyStimulus(1, 0, 1);
    valid_in = 1'b0;
    ready_in = 1'b0;
    #2;
    checkOutput("word2 data no bubble", data_out, EXP_0110);
    checkOutput("word2 valid no bubble", valid_out, 1'b1);
    applyStimulus(0, 0, 1);
    #2;
    checkOutput("word2 taken", valid_out, 1'b0);
    checkOutput("data kept after take", data_out, EXP_0110);

    $display("[TB] continuous stream, three words");
    for (int i = 0; i < 12; i++)
      applyStimulus(1, 1'($urandom_range(0, 1)), 1);
    applyStimulus(0, 0, 1);

    $display("[TB] gaps between bits");
    applyStimulus(1, 1, 1);
    applyStimulus(0, 0, 1);
    applyStimulus(1, 0, 1);
    applyStimulus(0, 1, 1);
    applyStimulus(1, 1, 1);
    applyStimulus(0, 0, 1);
    applyStimulus(1, 1, 1);
    valid_in = 1'b0;
    #2;
    checkOutput("gapped word data", data_out, EXP_1011);
    checkOutput("gapped word valid", valid_out, 1'b1);
    applyStimulus(0, 0, 1);

    $display("[TB] reset in mid-word with a word pending");
    applyStimulus(1, 1, 0);
    applyStimulus(1, 1, 0);
    applyStimulus(1, 0, 0);
    applyStimulus(1, 1, 0);
    applyStimulus(1, 1, 0);
    applyStimulus(1, 1, 0);
    valid_in = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    checkOutput("async reset valid_out", valid_out, 1'b0);
    checkOutput("async reset data_out", data_out, '0);
    checkOutput("async reset ready_out", ready_out, 1'b0);
    @(posedge clk_in);
    #2 rst_n = 1'b1;
    applyStimulus(1, 0, 1);
    applyStimulus(1, 0, 1);
    applyStimulus(1, 1, 1);
    applyStimulus(1, 1, 1);
    valid_in = 1'b0;
    #2;
    checkOutput("post-reset word data", data_out, EXP_0011);
    checkOutput("post-reset word valid", valid_out, 1'b1);

    $display("[TB] random traffic");
    for (int i = 0; i < 200; i++)
      applyStimulus(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)));
    applyStimulus(0, 0, 1);
    applyStimulus(0, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
